// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for a 5-stage pipeline using Tuse/Tnew tracking.
// Optional HAZARD_STATS_EN adds a saturating stall_cnt output.
module hazard_fwd_ctrl #(
  parameter int unsigned RA_W = 5,
  parameter int unsigned T_W  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] rs_D,
  input  logic [RA_W-1:0] rt_D,
  input  logic            use_rs_D,
  input  logic            use_rt_D,
  input  logic [T_W-1:0]  Tuse_rs_D,
  input  logic [T_W-1:0]  Tuse_rt_D,
  input  logic [RA_W-1:0] A3_D,
  input  logic [T_W-1:0]  Tnew_D,
  output logic            stall,
  output logic [1:0]      MF_CMPA_Sel,
  output logic [1:0]      MF_CMPB_Sel,
  output logic [1:0]      MF_ALUA_Sel,
  output logic [1:0]      MF_ALUB_Sel,
  output logic            MF_DM_Sel
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  localparam logic [1:0] SelM  = 2'b10;
  localparam logic [1:0] SelW  = 2'b01;
  localparam logic [1:0] SelRf = 2'b00;

  logic [RA_W-1:0] rs_e_q, rt_e_q, a3_e_q;
  logic [T_W-1:0]  tnew_e_q;
  logic [RA_W-1:0] rt_m_q, a3_m_q;
  logic [T_W-1:0]  tnew_m_q;
  logic [RA_W-1:0] a3_w_q;

  logic [RA_W-1:0] rs_e_d, rt_e_d, a3_e_d;
  logic [T_W-1:0]  tnew_e_d, tnew_m_d;
  logic            stall_rs, stall_rt;

  function automatic logic hazard(input logic            used,
                                  input logic [RA_W-1:0] r,
                                  input logic [T_W-1:0]  tuse,
                                  input logic [RA_W-1:0] a3_e,
                                  input logic [T_W-1:0]  tnew_e,
                                  input logic [RA_W-1:0] a3_m,
                                  input logic [T_W-1:0]  tnew_m);
    return used && (r != '0) &&
           (((a3_e == r) && (tnew_e > tuse)) || ((a3_m == r) && (tnew_m > tuse)));
  endfunction

  // The M-stage producer wins over W so the youngest value is used.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] r,
                                         input logic [RA_W-1:0] a3_m,
                                         input logic [T_W-1:0]  tnew_m,
                                         input logic [RA_W-1:0] a3_w);
    if (r == '0)                          return SelRf;
    else if (a3_m == r && tnew_m == '0)   return SelM;
    else if (a3_w == r)                   return SelW;
    else                                  return SelRf;
  endfunction

  always_comb begin
    stall_rs    = hazard(use_rs_D, rs_D, Tuse_rs_D, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q);
    stall_rt    = hazard(use_rt_D, rt_D, Tuse_rt_D, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q);
    stall       = stall_rs | stall_rt;
    MF_CMPA_Sel = fwd_sel(rs_D, a3_m_q, tnew_m_q, a3_w_q);
    MF_CMPB_Sel = fwd_sel(rt_D, a3_m_q, tnew_m_q, a3_w_q);
    MF_ALUA_Sel = fwd_sel(rs_e_q, a3_m_q, tnew_m_q, a3_w_q);
    MF_ALUB_Sel = fwd_sel(rt_e_q, a3_m_q, tnew_m_q, a3_w_q);
    MF_DM_Sel   = (rt_m_q != '0) && (a3_w_q == rt_m_q);
  end

  always_comb begin
    rs_e_d   = rs_D;
    rt_e_d   = rt_D;
    a3_e_d   = A3_D;
    tnew_e_d = Tnew_D;
    if (stall) begin
      rs_e_d   = '0;
      rt_e_d   = '0;
      a3_e_d   = '0;
      tnew_e_d = '0;
    end
    tnew_m_d = (tnew_e_q == '0) ? '0 : tnew_e_q - T_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_e_q   <= '0;
      rt_e_q   <= '0;
      a3_e_q   <= '0;
      tnew_e_q <= '0;
      rt_m_q   <= '0;
      a3_m_q   <= '0;
      tnew_m_q <= '0;
      a3_w_q   <= '0;
    end else begin
      rs_e_q   <= rs_e_d;
      rt_e_q   <= rt_e_d;
      a3_e_q   <= a3_e_d;
      tnew_e_q <= tnew_e_d;
      rt_m_q   <= rt_e_q;
      a3_m_q   <= a3_e_q;
      tnew_m_q <= tnew_m_d;
      a3_w_q   <= a3_m_q;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl: an instruction-level pipeline model predicts
// stall and forwarding selects each cycle; a monitor compares at the falling edge.
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, A3_D;
  logic       use_rs_D, use_rt_D;
  logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_D;
  logic       stall, MF_DM_Sel;
  logic [1:0] MF_CMPA_Sel, MF_CMPB_Sel, MF_ALUA_Sel, MF_ALUB_Sel;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  hazard_fwd_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .rs_D       (rs_D),
    .rt_D       (rt_D),
    .use_rs_D   (use_rs_D),
    .use_rt_D   (use_rt_D),
    .Tuse_rs_D  (Tuse_rs_D),
    .Tuse_rt_D  (Tuse_rt_D),
    .A3_D       (A3_D),
    .Tnew_D     (Tnew_D),
    .stall      (stall),
    .MF_CMPA_Sel(MF_CMPA_Sel),
    .MF_CMPB_Sel(MF_CMPB_Sel),
    .MF_ALUA_Sel(MF_ALUA_Sel),
    .MF_ALUB_Sel(MF_ALUB_Sel),
    .MF_DM_Sel  (MF_DM_Sel)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  typedef struct {
    int rs, rt;
    bit urs, urt;
    int trs, trt;
    int a3, tnew;
  } instr_t;

  typedef struct {
    int stall, cmpa, cmpb, alua, alub, dm;
    longint cnt;
  } exp_t;

  exp_t   sb_q[$];
  instr_t pipe[3];   // 0 = E, 1 = M, 2 = W
  instr_t cur;
  longint model_cnt;
  int     errors = 0;
  int     checks = 0;
  int     last_stall;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(int rs, int rt, bit urs, bit urt, int trs, int trt,
                                int a3, int tnew);
    instr_t i;
    i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
    i.trs = trs; i.trt = trt; i.a3 = a3; i.tnew = tnew;
    return i;
  endfunction

  function automatic instr_t bubble();
    return mk(0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Cycles still needed by a producer that has spent `age` cycles past E entry.
  function automatic int remaining(instr_t p, int age);
    return (p.tnew > age) ? p.tnew - age : 0;
  endfunction

  function automatic int must_wait(int r, bit used, int tuse);
    if (!used || r == 0) return 0;
    if (pipe[0].a3 == r && remaining(pipe[0], 0) > tuse) return 1;
    if (pipe[1].a3 == r && remaining(pipe[1], 1) > tuse) return 1;
    return 0;
  endfunction

  function automatic int source(int r);
    if (r == 0) return 0;
    if (pipe[1].a3 == r && remaining(pipe[1], 1) == 0) return 2;
    if (pipe[2].a3 == r) return 1;
    return 0;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e.stall = must_wait(cur.rs, cur.urs, cur.trs) | must_wait(cur.rt, cur.urt, cur.trt);
    e.cmpa  = source(cur.rs);
    e.cmpb  = source(cur.rt);
    e.alua  = source(pipe[0].rs);
    e.alub  = source(pipe[0].rt);
    e.dm    = (pipe[1].rt != 0 && pipe[2].a3 == pipe[1].rt) ? 1 : 0;
    e.cnt   = model_cnt;
    return e;
  endfunction

  task automatic drive(input instr_t d);
    cur       = d;
    rs_D      = 5'(d.rs);
    rt_D      = 5'(d.rt);
    use_rs_D  = d.urs;
    use_rt_D  = d.urt;
    Tuse_rs_D = 2'(d.trs);
    Tuse_rt_D = 2'(d.trt);
    A3_D      = 5'(d.a3);
    Tnew_D    = 2'(d.tnew);
  endtask

  // One clock of D-stage presentation: predict, queue, then advance the model.
  task automatic step(input instr_t d);
    exp_t e;
    drive(d);
    e = predict();
    sb_q.push_back(e);
    last_stall = e.stall;
    @(posedge clk);
    if (e.stall != 0 && model_cnt != 64'hFFFF_FFFF) model_cnt++;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = (e.stall != 0) ? bubble() : d;
    #1;
  endtask

  // Hold the instruction in D until it is accepted.
  task automatic issue(input instr_t d);
    for (int t = 0; t < 4; t++) begin
      step(d);
      if (last_stall == 0) return;
    end
    chk("issue_bound", 1, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = bubble();
    model_cnt = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("stall", stall, e.stall);
        chk("cmpa",  MF_CMPA_Sel, e.cmpa);
        chk("cmpb",  MF_CMPB_Sel, e.cmpb);
        chk("alua",  MF_ALUA_Sel, e.alua);
        chk("alub",  MF_ALUB_Sel, e.alub);
        chk("dm",    MF_DM_Sel, e.dm);
`ifdef HAZARD_STATS_EN
        chk("stall_cnt", stall_cnt, e.cnt);
`endif
      end
    end
  end

  initial begin : stim
    instr_t nop;
    nop = bubble();
    model_reset();
    drive(nop);
    reset = 1'b1;
    #1;
    chk("reset_stall", stall, 0);
    chk("reset_alua", MF_ALUA_Sel, 0);
    chk("reset_dm", MF_DM_Sel, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // lw $8 then addu reading $8 in E
    issue(mk(0, 0, 0, 0, 0, 0, 8, 2));
    issue(mk(8, 0, 1, 0, 1, 0, 12, 1));
    for (int i = 0; i < 3; i++) step(nop);
    // addu $9 then beq on $9
    issue(mk(0, 0, 0, 0, 0, 0, 9, 1));
    issue(mk(9, 0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) step(nop);
    // addu $10 then sw storing $10, directly and two behind
    issue(mk(0, 0, 0, 0, 0, 0, 10, 1));
    issue(mk(0, 10, 1, 1, 1, 2, 0, 0));
    issue(mk(0, 0, 0, 0, 0, 0, 10, 1));
    step(nop);
    issue(mk(0, 10, 1, 1, 1, 2, 0, 0));
    for (int i = 0; i < 3; i++) step(nop);
    // write to $0 then consumer of $0
    issue(mk(0, 0, 0, 0, 0, 0, 0, 1));
    issue(mk(0, 0, 1, 1, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) step(nop);
    // back-to-back writes to $11, then consumer in E
    issue(mk(0, 0, 0, 0, 0, 0, 11, 1));
    issue(mk(0, 0, 0, 0, 0, 0, 11, 1));
    issue(mk(11, 0, 1, 0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) step(nop);

    // Reset while a stall is being presented
    issue(mk(0, 0, 0, 0, 0, 0, 8, 2));
    drive(mk(8, 0, 1, 0, 1, 0, 12, 1));
    sb_q.push_back(predict());
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_cmpa", MF_CMPA_Sel, 0);
    chk("rst_mid_alua", MF_ALUA_Sel, 0);
`ifdef HAZARD_STATS_EN
    chk("rst_mid_cnt", stall_cnt, 0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    // empty pipeline: a consumer of $8 must not stall or forward
    issue(mk(8, 8, 1, 1, 0, 0, 0, 0));

    for (int n = 0; n < 300; n++) begin
      issue(mk($urandom_range(3), $urandom_range(3), 1'($urandom_range(1)),
               1'($urandom_range(1)), $urandom_range(2), $urandom_range(2),
               $urandom_range(3), $urandom_range(2)));
    end
    step(nop);
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
Central hazard and forwarding controller for the 5-stage pipeline; it drives the MF_* select lines that the D, E and M stage forwarding muxes consume.
- Shadow pipeline: keeps its own copy of destination-register/Tnew and source-register tags for E, M and W, advanced every clock.
- Outputs: a D-stage stall (bubble into E) and per-operand forwarding selects, using the Tuse/Tnew method.
- Mux encoding everywhere: 2'b10 = RFWD_M, 2'b01 = RFWD_W, 2'b00 = register-file / pipeline value.

Parameters:
- RA_W, 5, register address width
- T_W, 2, width of Tnew/Tuse fields

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rs_D  input  RA_W  D-stage rs field
- rt_D  input  RA_W  D-stage rt field
- use_rs_D  input  1  instruction in D reads rs
- use_rt_D  input  1  instruction in D reads rt
- Tuse_rs_D  input  T_W  cycles from D until rs is consumed (0 = D comparator, 1 = E ALU, 2 = M store)
- Tuse_rt_D  input  T_W  same for rt
- A3_D  input  RA_W  destination register of D instruction (0 if no write)
- Tnew_D  input  T_W  cycles, counted from entry to E, until result is ready (ALU = 1, lw = 2, none = 0)
- stall  output  1  hold PC and D register, insert bubble into E
- MF_CMPA_Sel  output  2  D comparator operand A select
- MF_CMPB_Sel  output  2  D comparator operand B select
- MF_ALUA_Sel  output  2  E ALU A select
- MF_ALUB_Sel  output  2  E ALU B select, before BSel
- MF_DM_Sel  output  1  M store-data select (1 = RFWD_W)

Behaviour:
- Shadow registers:
  - E stage: rs_E, rt_E, A3_E, Tnew_E.
  - M stage: rt_M, A3_M, Tnew_M.
  - W stage: A3_W.
- Reset (async): all shadow registers go to 0. Outputs are then combinationally stall=0 and all selects=0.
- Per posedge, no stall:
  - E <= D fields.
  - M <= E, with Tnew_M = (Tnew_E==0) ? 0 : Tnew_E-1.
  - W <= M.
- Per posedge, stall=1:
  - E loads a bubble: all fields 0, so A3_E=0.
  - M and W advance normally.
- Tnew saturates at 0 and never wraps. Tnew_W is implicitly 0.
- stall (combinational) = stall_rs | stall_rt.
  - stall_rs = use_rs_D & (rs_D!=0) & ((A3_E==rs_D & Tnew_E>Tuse_rs_D) | (A3_M==rs_D & Tnew_M>Tuse_rs_D)).
  - stall_rt is the same with rt.
- D comparator selects (CMPA uses rs_D, CMPB uses rt_D); register 0 always yields 00:
  - 10 if A3_M==reg and Tnew_M==0.
  - else 01 if A3_W==reg.
  - else 00.
- E ALU selects (ALUA uses rs_E, ALUB uses rt_E), with the same rules.
- M store select: MF_DM_Sel = (rt_M!=0) & (A3_W==rt_M).
- Priority: the M match always beats the W match, so the youngest producer wins.
- The E-stage producer is never forwarded from; when it is not ready, D stalls instead.
- Outputs are purely combinational from the shadow registers and D inputs; no output latency.
- Reset mid-stall: stall drops in the same cycle reset asserts, and the pipeline restarts empty.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - Adds output stall_cnt, 32 bits.
  - Increments on every posedge where stall=1, saturating at 32'hFFFFFFFF.
  - Cleared by reset.
- When undefined: the port and counter do not exist, and behaviour is otherwise identical.

Test Plan:
- lw $8 (A3_D=8, Tnew_D=2), then addu using rs=8 (Tuse=1) -> stall=1 for exactly 1 cycle; next cycle stall=0 and MF_ALUA_Sel=01 when addu is in E.
- addu $9 (Tnew=1), then beq reading rs=9 (Tuse=0) -> stall=1 one cycle; then MF_CMPA_Sel=10.
- addu $10, then sw with rt=10 (Tuse=2) -> no stall; MF_ALUB_Sel=10 in E, or MF_DM_Sel=1 if the producer is two ahead.
- Write to $0 (A3_D=0, Tnew=1), then consumer of rs=0 -> stall=0 and all selects 00.
- Back-to-back writes to $11 (in M and W), then consumer in E -> MF_ALUA_Sel=10, showing M priority.
- Assert reset while stall=1 -> stall=0 immediately and shadow registers 0. With HAZARD_STATS_EN, also check stall_cnt=0 after reset and +1 per stalled cycle.
